dllp_ack_nak_rx: RTL and testbench

Receive-side Ack/Nak DLLP parser that sits directly upstream of retry_management and drives its ack_nack_i, ack_nack_vld_i and ack_seq_num_i inputs. It takes 2-beat DLLP frames over 32-bit AXI-Stream from the physical/framing layer, optionally checks the CRC-16, and validates the Ack/Nak sequence number against AckD_SEQ and NEXT_TRANSMIT_SEQ. It forwards only new, legal Ack/Nak events and flags duplicates, protocol errors and malformed frames.

---
 rtl/dllp_ack_nak_rx.sv | 205 ++++++++++++++++++++
 tb/tb_dllp_ack_nak_rx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dllp_ack_nak_rx.sv
// Receive-side Ack/Nak DLLP parser feeding retry_management: frames 2-beat DLLPs,
// validates the sequence number against AckD_SEQ / NEXT_TRANSMIT_SEQ. Optional CRC-16 check: DLLP_CRC_CHECK_EN.
module dllp_ack_nak_rx #(
   parameter int         DATA_WIDTH    = 32,
   parameter int         SEQ_WIDTH     = 12,
   parameter int         ERR_CNT_WIDTH = 8,
   parameter logic [7:0] ACK_TYPE      = 8'h00,
   parameter logic [7:0] NAK_TYPE      = 8'h10
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [DATA_WIDTH-1:0]    s_axis_tdata_i,
   input  logic [3:0]               s_axis_tkeep_i,
   input  logic                     s_axis_tvalid_i,
   input  logic                     s_axis_tlast_i,
   output logic                     s_axis_tready_o,
   input  logic [SEQ_WIDTH-1:0]     next_tx_seq_i,
   output logic                     ack_nack_o,
   output logic                     ack_nack_vld_o,
   output logic [SEQ_WIDTH-1:0]     ack_seq_num_o,
   output logic [SEQ_WIDTH-1:0]     ackd_seq_o,
   output logic                     dup_ack_o,
   output logic                     protocol_err_o,
   output logic                     malformed_o,
   output logic                     crc_err_o,
   output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

   typedef enum logic [1:0] {IDLE, WAIT_CRC, DRAIN} state_e;

   state_e                   state_q, state_d;
   logic [7:0]               type_q, type_d;
   logic [SEQ_WIDTH-1:0]     seq_q, seq_d;
   logic                     ack_nack_q, ack_nack_d;
   logic                     vld_q, vld_d;
   logic [SEQ_WIDTH-1:0]     ack_seq_num_q, ack_seq_num_d;
   logic [SEQ_WIDTH-1:0]     ackd_q, ackd_d;
   logic                     dup_q, dup_d;
   logic                     perr_q, perr_d;
   logic                     mal_q, mal_d;
   logic                     crc_err_d;
   logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
   logic                     done, crc_ok, in_range;
   logic [SEQ_WIDTH-1:0]     d_tx, d_ack;
   logic [SEQ_WIDTH-1:0]     beat_seq;
   logic                     unused_bits;

   assign beat_seq    = SEQ_WIDTH'({s_axis_tdata_i[19:16], s_axis_tdata_i[31:24]});
   assign unused_bits = ^s_axis_tdata_i;

   // Both distances must fall in the lower half of the sequence space (mod 2^SEQ_WIDTH).
   assign d_tx     = next_tx_seq_i - SEQ_WIDTH'(1) - seq_q;
   assign d_ack    = seq_q - ackd_q;
   assign in_range = !d_tx[SEQ_WIDTH-1] && !d_ack[SEQ_WIDTH-1];

`ifdef DLLP_CRC_CHECK_EN
   logic [15:0] crc_exp_q, crc_exp_d;
   logic        crc_err_q;

   // Serial CRC-16 (0x100B), bytes fed LSB-first, complemented, bit-reversed per output byte.
   function automatic logic [15:0] dllp_crc(input logic [31:0] d);
      logic [15:0] c;
      logic [15:0] r;
      logic        fb;
      c = 16'hFFFF;
      for (int i = 0; i < 32; i++) begin
         fb = c[15] ^ d[i];
         c  = {c[14:0], 1'b0};
         if (fb) c = c ^ 16'h100B;
      end
      c = ~c;
      for (int i = 0; i < 8; i++) begin
         r[i]   = c[15-i];
         r[8+i] = c[7-i];
      end
      return r;
   endfunction

   assign crc_ok    = (s_axis_tdata_i[15:0] == crc_exp_q);
   assign crc_err_o = crc_err_q;
`else
   assign crc_ok    = 1'b1;
   assign crc_err_o = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      type_d        = type_q;
      seq_d         = seq_q;
      ack_nack_d    = ack_nack_q;
      ack_seq_num_d = ack_seq_num_q;
      ackd_d        = ackd_q;
      err_cnt_d     = err_cnt_q;
      vld_d         = 1'b0;
      dup_d         = 1'b0;
      perr_d        = 1'b0;
      mal_d         = 1'b0;
      crc_err_d     = 1'b0;
      done          = 1'b0;
`ifdef DLLP_CRC_CHECK_EN
      crc_exp_d     = crc_exp_q;
`endif
      if (s_axis_tvalid_i) begin
         case (state_q)
            IDLE: begin
               if (s_axis_tlast_i) begin
                  mal_d = 1'b1;
               end else if (s_axis_tkeep_i != 4'hF) begin
                  mal_d   = 1'b1;
                  state_d = DRAIN;
               end else begin
                  type_d  = s_axis_tdata_i[7:0];
                  seq_d   = beat_seq;
                  state_d = WAIT_CRC;
`ifdef DLLP_CRC_CHECK_EN
                  crc_exp_d = dllp_crc(s_axis_tdata_i[31:0]);
`endif
               end
            end
            WAIT_CRC: begin
               if (s_axis_tlast_i) begin
                  state_d = IDLE;
                  if (s_axis_tkeep_i == 4'h3) done = 1'b1;
                  else                        mal_d = 1'b1;
               end else begin
                  mal_d   = 1'b1;
                  state_d = DRAIN;
               end
            end
            DRAIN: begin
               if (s_axis_tlast_i) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      // A failed CRC drops the frame before type and sequence checks.
      if (done) begin
         if (!crc_ok) begin
            crc_err_d = 1'b1;
         end else if (type_q == ACK_TYPE || type_q == NAK_TYPE) begin
            if (!in_range) begin
               perr_d = 1'b1;
            end else if (type_q == ACK_TYPE && seq_q == ackd_q) begin
               dup_d = 1'b1;
            end else begin
               vld_d         = 1'b1;
               ack_nack_d    = (type_q == ACK_TYPE);
               ack_seq_num_d = seq_q;
               ackd_d        = seq_q;
            end
         end
      end

      if ((perr_d || mal_d || crc_err_d) && !(&err_cnt_q))
         err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         type_q        <= '0;
         seq_q         <= '0;
         ack_nack_q    <= 1'b0;
         vld_q         <= 1'b0;
         ack_seq_num_q <= '0;
         ackd_q        <= '1;
         dup_q         <= 1'b0;
         perr_q        <= 1'b0;
         mal_q         <= 1'b0;
         err_cnt_q     <= '0;
`ifdef DLLP_CRC_CHECK_EN
         crc_exp_q     <= '0;
         crc_err_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         type_q        <= type_d;
         seq_q         <= seq_d;
         ack_nack_q    <= ack_nack_d;
         vld_q         <= vld_d;
         ack_seq_num_q <= ack_seq_num_d;
         ackd_q        <= ackd_d;
         dup_q         <= dup_d;
         perr_q        <= perr_d;
         mal_q         <= mal_d;
         err_cnt_q     <= err_cnt_d;
`ifdef DLLP_CRC_CHECK_EN
         crc_exp_q     <= crc_exp_d;
         crc_err_q     <= crc_err_d;
`endif
      end
   end

   assign s_axis_tready_o = ~rst_i;
   assign ack_nack_o      = ack_nack_q;
   assign ack_nack_vld_o  = vld_q;
   assign ack_seq_num_o   = ack_seq_num_q;
   assign ackd_seq_o      = ackd_q;
   assign dup_ack_o       = dup_q;
   assign protocol_err_o  = perr_q;
   assign malformed_o     = mal_q;
   assign err_cnt_o       = err_cnt_q;

endmodule

// File: tb/tb_dllp_ack_nak_rx.sv
// Directed bench for dllp_ack_nak_rx: expected output events are queued as beats are
// driven and matched (value and cycle) whenever the DUT raises any strobe.
module tb_dllp_ack_nak_rx;

   typedef struct packed {
      logic        vld;
      logic        ack;
      logic [11:0] seq;
      logic [11:0] ackd;
      logic        dup;
      logic        perr;
      logic        mal;
      logic        crc;
      logic [7:0]  cnt;
   } obs_t;

   typedef struct {
      obs_t        o;
      int unsigned cyc;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] tdata = '0;
   logic [3:0]  tkeep = '0;
   logic        tvalid = 1'b0;
   logic        tlast = 1'b0;
   logic        tready;
   logic [11:0] next_tx = '0;
   logic        ack_nack, ack_vld, dup_ack, perr, mal, crc_err;
   logic [11:0] ack_seq, ackd_seq;
   logic [7:0]  err_cnt;

   int unsigned cyc = 0;
   int          tests = 0;
   int          fails = 0;
   ev_t         sb_q[$];
   logic [7:0]  exp_cnt = '0;
   logic        hold_ack = 1'b0;
   logic [11:0] hold_seq = '0;

   dllp_ack_nak_rx dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .s_axis_tdata_i  (tdata),
      .s_axis_tkeep_i  (tkeep),
      .s_axis_tvalid_i (tvalid),
      .s_axis_tlast_i  (tlast),
      .s_axis_tready_o (tready),
      .next_tx_seq_i   (next_tx),
      .ack_nack_o      (ack_nack),
      .ack_nack_vld_o  (ack_vld),
      .ack_seq_num_o   (ack_seq),
      .ackd_seq_o      (ackd_seq),
      .dup_ack_o       (dup_ack),
      .protocol_err_o  (perr),
      .malformed_o     (mal),
      .crc_err_o       (crc_err),
      .err_cnt_o       (err_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // PCIe DLLP CRC-16 reference, byte at a time.
   function automatic logic [15:0] ref_crc(input logic [31:0] d);
      logic [15:0] c;
      logic [15:0] r;
      logic [7:0]  b;
      c = 16'hFFFF;
      for (int k = 0; k < 4; k++) begin
         b = d[8*k +: 8];
         for (int j = 0; j < 8; j++) begin
            if (c[15] ^ b[j]) c = {c[14:0], 1'b0} ^ 16'h100B;
            else              c = {c[14:0], 1'b0};
         end
      end
      c = ~c;
      for (int j = 0; j < 8; j++) begin
         r[j]   = c[15-j];
         r[8+j] = c[7-j];
      end
      return r;
   endfunction

   function automatic logic [31:0] beat0(input logic [7:0] typ, input logic [11:0] seq);
      return {seq[7:0], 4'h0, seq[11:8], 8'h00, typ};
   endfunction

   task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic l);
      tdata = d; tkeep = k; tlast = l; tvalid = 1'b1;
      @(posedge clk); #1;
      tvalid = 1'b0; tlast = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] typ, input logic [11:0] seq, input logic flip);
      logic [31:0] d;
      logic [15:0] c;
      d = beat0(typ, seq);
      c = ref_crc(d) ^ {15'd0, flip};
      drive(d, 4'hF, 1'b0);
      drive({16'h0, c}, 4'h3, 1'b1);
   endtask

   // Queue one expected strobe cycle, visible lat cycles from now.
   task automatic expect_ev(input logic vld, input logic ack, input logic [11:0] seq,
                            input logic [11:0] ackd, input logic dup, input logic pe,
                            input logic ml, input logic ce, input int lat);
      ev_t e;
      if (vld) begin hold_ack = ack; hold_seq = seq; end
      if ((pe || ml || ce) && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      e.o   = {vld, hold_ack, hold_seq, ackd, dup, pe, ml, ce, exp_cnt};
      e.cyc = cyc + lat;
      sb_q.push_back(e);
   endtask

   always @(negedge clk) begin
      obs_t ob;
      ev_t  e;
      if (!rst && (ack_vld || dup_ack || perr || mal || crc_err)) begin
         ob = {ack_vld, ack_nack, ack_seq, ackd_seq, dup_ack, perr, mal, crc_err, err_cnt};
         tests++;
         assert (sb_q.size() > 0) else begin
            fails++;
            $error("FAIL unexpected_event: observed %h expected none", ob);
         end
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("event", 64'(ob), 64'(e.o));
            chk("event_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("tready_in_reset", 64'(tready), 64'd0);
      rst = 1'b0;
      #1;
      chk("tready_after_reset", 64'(tready), 64'd1);
      chk("reset_outputs", 64'({ack_vld, ack_nack, ack_seq, ackd_seq, dup_ack, perr, mal, crc_err, err_cnt}),
          64'({1'b0, 1'b0, 12'h000, 12'hFFF, 4'b0000, 8'h00}));
      @(posedge clk); #1;

      // Basic Ack, duplicate, Nak, out-of-range
      next_tx = 12'd5;
      expect_ev(1, 1, 12'd3, 12'd3, 0, 0, 0, 0, 2);   send_frame(8'h00, 12'd3, 0);
      expect_ev(0, 0, 12'd0, 12'd3, 1, 0, 0, 0, 2);   send_frame(8'h00, 12'd3, 0);
      expect_ev(1, 0, 12'd3, 12'd3, 0, 0, 0, 0, 2);   send_frame(8'h10, 12'd3, 0);
      expect_ev(0, 0, 12'd0, 12'd3, 0, 1, 0, 0, 2);   send_frame(8'h00, 12'd10, 0);
      send_frame(8'h20, 12'd7, 0);

      // Walk AckD_SEQ up to 4094, then wrap to 0
      next_tx = 12'd2050;
      expect_ev(1, 1, 12'd2000, 12'd2000, 0, 0, 0, 0, 2); send_frame(8'h00, 12'd2000, 0);
      next_tx = 12'd3100;
      expect_ev(1, 1, 12'd3000, 12'd3000, 0, 0, 0, 0, 2); send_frame(8'h00, 12'd3000, 0);
      next_tx = 12'd2;
      expect_ev(1, 1, 12'd4094, 12'd4094, 0, 0, 0, 0, 2); send_frame(8'h00, 12'd4094, 0);
      expect_ev(1, 1, 12'd0, 12'd0, 0, 0, 0, 0, 2);       send_frame(8'h00, 12'd0, 0);
      expect_ev(0, 0, 12'd0, 12'd0, 0, 1, 0, 0, 2);       send_frame(8'h10, 12'd4095, 0);
      expect_ev(1, 0, 12'd1, 12'd1, 0, 0, 0, 0, 2);       send_frame(8'h10, 12'd1, 0);

      // Framing errors
      expect_ev(0, 0, 12'd0, 12'd1, 0, 0, 1, 0, 1);
      drive(32'h0, 4'hF, 1'b1);
      expect_ev(0, 0, 12'd0, 12'd1, 0, 0, 1, 0, 2);
      drive(beat0(8'h00, 12'd2), 4'hF, 1'b0);
      drive(32'h0, 4'h3, 1'b0);
      drive(32'h0, 4'h3, 1'b1);
      next_tx = 12'd3;
      expect_ev(1, 1, 12'd2, 12'd2, 0, 0, 0, 0, 2);       send_frame(8'h00, 12'd2, 0);
      expect_ev(0, 0, 12'd0, 12'd2, 0, 0, 1, 0, 1);
      drive(32'h0, 4'h7, 1'b0);
      drive(32'h0, 4'hF, 1'b1);
      expect_ev(0, 0, 12'd0, 12'd2, 0, 0, 1, 0, 2);
      drive(beat0(8'h00, 12'd2), 4'hF, 1'b0);
      drive(32'h0, 4'hF, 1'b1);

      // CRC bit0 flipped, then the same frame with the correct CRC
      next_tx = 12'd4;
`ifdef DLLP_CRC_CHECK_EN
      expect_ev(0, 0, 12'd0, 12'd2, 0, 0, 0, 1, 2);       send_frame(8'h00, 12'd3, 1);
      expect_ev(1, 1, 12'd3, 12'd3, 0, 0, 0, 0, 2);       send_frame(8'h00, 12'd3, 0);
`else
      expect_ev(1, 1, 12'd3, 12'd3, 0, 0, 0, 0, 2);       send_frame(8'h00, 12'd3, 1);
      expect_ev(0, 0, 12'd0, 12'd3, 1, 0, 0, 0, 2);       send_frame(8'h00, 12'd3, 0);
`endif

      // Error counter saturation with back-to-back malformed beats
      for (int i = 0; i < 260; i++) begin
         expect_ev(0, 0, 12'd0, 12'd3, 0, 0, 1, 0, 1);
         drive(32'h0, 4'hF, 1'b1);
      end

      // Reset mid-frame; leftover beat1 is malformed
      drive(beat0(8'h00, 12'd3), 4'hF, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("tready_mid_reset", 64'(tready), 64'd0);
      rst = 1'b0;
      exp_cnt = '0; hold_ack = 1'b0; hold_seq = '0;
      expect_ev(0, 0, 12'd0, 12'hFFF, 0, 0, 1, 0, 1);
      drive({16'h0, ref_crc(beat0(8'h00, 12'd3))}, 4'h3, 1'b1);
      next_tx = 12'd5;
      expect_ev(1, 1, 12'd3, 12'd3, 0, 0, 0, 0, 2);       send_frame(8'h00, 12'd3, 0);

      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
      @(negedge clk);
      chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
